// File: rtl/inst_encoder_writer.sv
// Packs decoded RV32I fields into instruction words and writes them to
// consecutive instruction-memory addresses through a one-entry output stage.
module inst_encoder_writer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RS     = 5,
  parameter int unsigned RD     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op_code,
  input  logic [3:0]        sub_op_code,
  input  logic [RS-1:0]     rs1,
  input  logic [RS-1:0]     rs2,
  input  logic [RD-1:0]     rd,
  input  logic [31:0]       imm,
  input  logic [4:0]        shift_size,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_REG    = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {EMPTY, LOADED, FULL} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;

  logic [31:0]         enc_word;
  logic                op_ok;
  logic [2:0]          f3;
  logic [4:0]          rs1_f, rs2_f, rd_f;
  logic                accept, commit;

  assign rs1_f = 5'(rs1);
  assign rs2_f = 5'(rs2);
  assign rd_f  = 5'(rd);

  always_comb begin
    f3            = sub_op_code[2:0];
    op_ok         = 1'b1;
    enc_word      = '0;
    enc_word[1:0] = 2'b11;
    enc_word[6:2] = op_code;
    case (op_code)
      OP_LUI, OP_AUIPC: begin
        enc_word[31:12] = imm[31:12];
        enc_word[11:7]  = rd_f;
      end
      OP_IMM: begin
        enc_word[19:15] = rs1_f;
        enc_word[14:12] = f3;
        enc_word[11:7]  = rd_f;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          enc_word[31:25] = {1'b0, sub_op_code[3], 5'b0};
          enc_word[24:20] = shift_size;
        end else begin
          enc_word[31:20] = imm[11:0];
        end
      end
      OP_LOAD, OP_JALR: begin
        enc_word[31:20] = imm[11:0];
        enc_word[19:15] = rs1_f;
        enc_word[14:12] = (op_code == OP_JALR) ? 3'b000 : f3;
        enc_word[11:7]  = rd_f;
      end
      OP_REG: begin
        enc_word[31:25] = {1'b0, sub_op_code[3], 5'b0};
        enc_word[24:20] = rs2_f;
        enc_word[19:15] = rs1_f;
        enc_word[14:12] = f3;
        enc_word[11:7]  = rd_f;
      end
      OP_STORE: begin
        enc_word[31:25] = imm[11:5];
        enc_word[24:20] = rs2_f;
        enc_word[19:15] = rs1_f;
        enc_word[14:12] = f3;
        enc_word[11:7]  = imm[4:0];
      end
      OP_BRANCH: begin
        enc_word[31]    = imm[12];
        enc_word[30:25] = imm[10:5];
        enc_word[24:20] = rs2_f;
        enc_word[19:15] = rs1_f;
        enc_word[14:12] = f3;
        enc_word[11:8]  = imm[4:1];
        enc_word[7]     = imm[11];
      end
      OP_JAL: begin
        enc_word[31]    = imm[20];
        enc_word[30:21] = imm[10:1];
        enc_word[20]    = imm[11];
        enc_word[19:12] = imm[19:12];
        enc_word[11:7]  = rd_f;
      end
      default: op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign accept = in_valid && in_ready;
  assign commit = (state_q == LOADED) && mem_ready;

  // The held word's address is addr_q; a bundle accepted alongside a commit
  // lands at the incremented address, which is exactly addr_d.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    if (clear) begin
      state_d = EMPTY;
      addr_d  = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (accept && !op_ok) err_d = 1'b1;
      if (commit) begin
        addr_d  = addr_q + 1'b1;
        count_d = count_q + 1'b1;
      end
      case (state_q)
        EMPTY: begin
          if (accept && op_ok) begin
            state_d = LOADED;
            wdata_d = enc_word;
          end
        end
        LOADED: begin
          if (commit) begin
            if (count_q + 1'b1 == CAPACITY) begin
              state_d = FULL;
            end else if (accept && op_ok) begin
              state_d = LOADED;
              wdata_d = enc_word;
            end else begin
              state_d = EMPTY;
            end
          end
        end
        default: state_d = FULL;
      endcase
    end
  end

  always_comb begin
    mem_we    = (state_q == LOADED);
    full      = (state_q == FULL);
    in_ready  = !rst && (state_q != FULL) && ((state_q == EMPTY) || mem_ready);
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    count     = count_q;
    err       = err_q;
  end

endmodule
